// File: rtl/rng_pkg.sv
// Shared definitions for the xorshift word source: FSM state encoding and
// the default shift triple used by both the top and the step function.
package rng_pkg;

  // Controller states: one priming step, free running, or discarding words
  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_SKIP  = 2'd2
  } rng_state_t;

  // Default full-period triple for a 16-bit xorshift generator
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_SA     = 3;
  localparam int DEF_SB     = 11;
  localparam int DEF_SC     = 7;
  localparam int DEF_SKIP_W = 8;

endpackage

// File: rtl/xorshift_step.sv
// Pure combinational xorshift step: y = f(x) using a left/right/left shift
// triple. The function is a bijection, so a nonzero input never maps to zero.
module xorshift_step
  import rng_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SA    = DEF_SA,
  parameter int SB    = DEF_SB,
  parameter int SC    = DEF_SC
) (
  input  logic [WIDTH-1:0] i_x,
  output logic [WIDTH-1:0] o_y
);

  logic [WIDTH-1:0] w_stageA;
  logic [WIDTH-1:0] w_stageB;

  // Three xor-shift stages, each truncated to the state width
  always_comb begin
    w_stageA = i_x ^ (i_x << SA);
    w_stageB = w_stageA ^ (w_stageA >> SB);
    o_y      = w_stageB ^ (w_stageB << SC);
  end

endmodule

// File: rtl/xorshift_stream.sv
// Xorshift pseudo-random word source with a valid/ready output, runtime
// reseeding and skip-ahead. The state register doubles as the output word.
module xorshift_stream
  import rng_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter int               SA           = DEF_SA,
  parameter int               SB           = DEF_SB,
  parameter int               SC           = DEF_SC,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               SKIP_W       = DEF_SKIP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [WIDTH-1:0]  seed,
  input  logic              skip_valid,
  input  logic [SKIP_W-1:0] skip_cnt,
  output logic              skip_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              busy,
  output logic [31:0]       count
);

  // A zero seed would lock the generator at zero forever, and the shift
  // network is only meaningful for the supported width range.
  if (DEFAULT_SEED == '0) begin : g_badSeed
    $error("xorshift_stream: DEFAULT_SEED must be nonzero");
  end
  if (WIDTH < 8 || WIDTH > 64) begin : g_badWidth
    $error("xorshift_stream: WIDTH must be within 8..64");
  end

  localparam logic [SKIP_W-1:0] REM_ONE = {{(SKIP_W-1){1'b0}}, 1'b1};

  rng_state_t        r_state;
  rng_state_t        w_stateNext;
  logic [WIDTH-1:0]  r_x;
  logic [WIDTH-1:0]  w_xNext;
  logic [WIDTH-1:0]  w_fx;
  logic              r_outValid;
  logic              w_outValidNext;
  logic [31:0]       r_count;
  logic [31:0]       w_countNext;
  logic [SKIP_W-1:0] r_rem;
  logic [SKIP_W-1:0] w_remNext;
  logic              w_handshake;

  xorshift_step #(
    .WIDTH (WIDTH),
    .SA    (SA),
    .SB    (SB),
    .SC    (SC)
  ) u_step (
    .i_x (r_x),
    .o_y (w_fx)
  );

  assign w_handshake = r_outValid & out_ready;
  assign out_valid   = r_outValid;
  assign out_data    = r_x;
  assign count       = r_count;
  assign skip_ready  = (r_state == ST_RUN);
  assign busy        = (r_state != ST_RUN);

  // State, generator word, valid flag, skip remainder and handshake counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_PRIME;
      r_x        <= DEFAULT_SEED;
      r_outValid <= 1'b0;
      r_count    <= 32'd0;
      r_rem      <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_x        <= w_xNext;
      r_outValid <= w_outValidNext;
      r_count    <= w_countNext;
      r_rem      <= w_remNext;
    end
  end

  // Next-state logic: reseed wins over everything, otherwise per-state stepping
  always_comb begin
    w_stateNext    = r_state;
    w_xNext        = r_x;
    w_outValidNext = r_outValid;
    w_countNext    = r_count;
    w_remNext      = r_rem;

    if (seed_load) begin
      w_xNext        = (seed == '0) ? DEFAULT_SEED : seed;
      w_outValidNext = 1'b0;
      w_countNext    = 32'd0;
      w_remNext      = '0;
      w_stateNext    = ST_PRIME;
    end else begin
      case (r_state)
        ST_PRIME: begin
          w_xNext        = w_fx;
          w_outValidNext = 1'b1;
          w_stateNext    = ST_RUN;
        end
        ST_RUN: begin
          if (w_handshake) begin
            w_xNext     = w_fx;
            w_countNext = r_count + 32'd1;
          end
          if (skip_valid && (skip_cnt != '0)) begin
            w_outValidNext = 1'b0;
            w_remNext      = skip_cnt;
            w_stateNext    = ST_SKIP;
          end
        end
        ST_SKIP: begin
          w_xNext   = w_fx;
          w_remNext = r_rem - REM_ONE;
          if (r_rem == REM_ONE) begin
            w_outValidNext = 1'b1;
            w_stateNext    = ST_RUN;
          end
        end
        default: begin
          w_stateNext = ST_PRIME;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xorshift_stream.sv
// Directed bench for xorshift_stream at WIDTH=16, triple 3/11/7, seed 1.
// Expected words come from hand-worked constants and a local model of f.
module tb_xorshift_stream;

  logic        clk;
  logic        rst;
  logic        seedLoad;
  logic [15:0] seed;
  logic        skipValid;
  logic [7:0]  skipCnt;
  logic        skipReady;
  logic        outValid;
  logic        outReady;
  logic [15:0] outData;
  logic        busy;
  logic [31:0] count;

  int vectorCount = 0;
  int missCount   = 0;

  logic [15:0] expX;
  logic [31:0] expCount;

  xorshift_stream #(
    .WIDTH        (16),
    .SA           (3),
    .SB           (11),
    .SC           (7),
    .DEFAULT_SEED (16'd1),
    .SKIP_W       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_load  (seedLoad),
    .seed       (seed),
    .skip_valid (skipValid),
    .skip_cnt   (skipCnt),
    .skip_ready (skipReady),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_data   (outData),
    .busy       (busy),
    .count      (count)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference xorshift step, written out stage by stage
  function automatic logic [15:0] refStep(input logic [15:0] v);
    logic [15:0] t;
    t = v;
    t = t ^ (t << 3);
    t = t ^ (t >> 11);
    t = t ^ (t << 7);
    return t;
  endfunction

  // Advance one clock and settle 1 ns past the edge
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectorCount++;
    assert (observed === expected)
    else begin
      missCount++;
      $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst       = 1'b1;
    seedLoad  = 1'b0;
    seed      = 16'd0;
    skipValid = 1'b0;
    skipCnt   = 8'd0;
    outReady  = 1'b0;

    // Scenario 1: reset state, then first words after release
    repeat (3) applyStimulus();
    checkOutput("rst_valid", outValid, 0);
    checkOutput("rst_data", outData, 16'h0001);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_busy", busy, 1);
    checkOutput("rst_skipready", skipReady, 0);
    rst = 1'b0;
    applyStimulus();
    checkOutput("s1_valid", outValid, 1);
    checkOutput("s1_data", outData, 16'h0489);
    checkOutput("s1_count", count, 0);
    checkOutput("s1_busy", busy, 0);
    checkOutput("s1_skipready", skipReady, 1);
    outReady = 1'b1;
    applyStimulus();
    checkOutput("s1_word2", outData, 16'h4245);
    checkOutput("s1_count2", count, 1);

    // Scenario 2: reseed with 4, pending word dropped despite out_ready
    seedLoad = 1'b1;
    seed     = 16'd4;
    applyStimulus();
    seedLoad = 1'b0;
    checkOutput("s2_valid0", outValid, 0);
    checkOutput("s2_busy", busy, 1);
    checkOutput("s2_count0", count, 0);
    applyStimulus();
    checkOutput("s2_valid1", outValid, 1);
    checkOutput("s2_data", outData, 16'h1224);
    checkOutput("s2_count", count, 0);

    // Scenario 3: zero seed falls back to the default stream
    seedLoad = 1'b1;
    seed     = 16'd0;
    outReady = 1'b0;
    applyStimulus();
    seedLoad = 1'b0;
    checkOutput("s3_x", outData, 16'h0001);
    applyStimulus();
    checkOutput("s3_valid", outValid, 1);
    checkOutput("s3_first", outData, 16'h0489);
    expX     = 16'h0489;
    expCount = 32'd0;
    outReady = 1'b1;
    for (int i = 0; i < 200; i++) begin
      applyStimulus();
      expX     = refStep(expX);
      expCount = expCount + 32'd1;
      checkOutput("s3_stream", outData, expX);
      checkOutput("s3_count", count, expCount);
    end

    // Scenario 4: stall holds word and count, release resumes the sequence
    outReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput("s4_hold_data", outData, expX);
      checkOutput("s4_hold_count", count, expCount);
    end
    outReady = 1'b1;
    applyStimulus();
    expX     = refStep(expX);
    expCount = expCount + 32'd1;
    checkOutput("s4_resume_data", outData, expX);
    checkOutput("s4_resume_count", count, expCount);

    // Scenario 5: skip 3 without a handshake, then a zero-length skip
    outReady  = 1'b0;
    skipValid = 1'b1;
    skipCnt   = 8'd3;
    applyStimulus();
    skipValid = 1'b0;
    checkOutput("s5_valid_drop", outValid, 0);
    checkOutput("s5_busy1", busy, 1);
    checkOutput("s5_skipready", skipReady, 0);
    applyStimulus();
    checkOutput("s5_busy2", busy, 1);
    applyStimulus();
    checkOutput("s5_busy3", busy, 1);
    applyStimulus();
    expX = refStep(refStep(refStep(expX)));
    checkOutput("s5_busy_end", busy, 0);
    checkOutput("s5_valid_back", outValid, 1);
    checkOutput("s5_data", outData, expX);
    checkOutput("s5_count", count, expCount);
    skipValid = 1'b1;
    skipCnt   = 8'd0;
    outReady  = 1'b1;
    applyStimulus();
    skipValid = 1'b0;
    expX     = refStep(expX);
    expCount = expCount + 32'd1;
    checkOutput("s5_zero_valid", outValid, 1);
    checkOutput("s5_zero_busy", busy, 0);
    checkOutput("s5_zero_data", outData, expX);
    checkOutput("s5_zero_count", count, expCount);

    // Scenario 6a: reseed aborts an in-flight skip
    outReady  = 1'b0;
    skipValid = 1'b1;
    skipCnt   = 8'd5;
    applyStimulus();
    skipValid = 1'b0;
    checkOutput("s6_skip_busy", busy, 1);
    seedLoad = 1'b1;
    seed     = 16'hBEEF;
    applyStimulus();
    seedLoad = 1'b0;
    checkOutput("s6_load_valid", outValid, 0);
    checkOutput("s6_load_data", outData, 16'hBEEF);
    checkOutput("s6_load_count", count, 0);
    applyStimulus();
    expX = refStep(16'hBEEF);
    checkOutput("s6_first_valid", outValid, 1);
    checkOutput("s6_first_data", outData, expX);
    checkOutput("s6_first_busy", busy, 0);

    // Scenario 6b: handshake and skip 2 together advance by three words
    outReady  = 1'b1;
    skipValid = 1'b1;
    skipCnt   = 8'd2;
    applyStimulus();
    outReady  = 1'b0;
    skipValid = 1'b0;
    checkOutput("s6_hs_count", count, 1);
    checkOutput("s6_hs_valid", outValid, 0);
    checkOutput("s6_hs_data", outData, refStep(expX));
    applyStimulus();
    checkOutput("s6_mid_busy", busy, 1);
    applyStimulus();
    expX = refStep(refStep(refStep(expX)));
    checkOutput("s6_end_valid", outValid, 1);
    checkOutput("s6_end_data", outData, expX);
    checkOutput("s6_end_count", count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
